// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU: opcode and FSM state
// encodings plus the most-negative-value helper used for the DIV overflow case.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_MUL  = 3'd4,
        OP_DIV  = 3'd5,
        OP_ADDR = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 16;

    // Two's-complement most-negative value for a w-bit word, right-aligned in 64 bits.
    function automatic logic [63:0] min_neg(input int unsigned w);
        return 64'd1 << (w - 32'd1);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// Unsigned iterative engine shared by MUL (shift-add) and DIV (restoring),
// one result bit per step; hi/lo end as product or remainder/quotient.
module seq_alu_muldiv_iter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] mag_a_i,
    input  logic [WIDTH-1:0] mag_b_i,
    output logic             last_iter_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   add_s, shl_s, sub_s;

    assign add_s = {1'b0, hi_q} + {1'b0, opb_q};
    assign shl_s = {hi_q, lo_q[WIDTH-1]};
    assign sub_s = shl_s - {1'b0, opb_q};

    assign last_iter_o = step_i && (cnt_q == CNT_W'(WIDTH - 1));
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

    // Next-state for the accumulator/shift pair and step counter.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        if (load_i) begin
            hi_d  = {WIDTH{1'b0}};
            lo_d  = mag_a_i;
            cnt_d = {CNT_W{1'b0}};
        end else if (step_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
                // sub_s[WIDTH] is the borrow: set means the trial subtract failed
                if (!sub_s[WIDTH]) begin
                    hi_d = sub_s[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shl_s[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {add_s, lo_q[WIDTH-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Engine state registers; divisor/multiplicand and mode are captured on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= {WIDTH{1'b0}};
            lo_q  <= {WIDTH{1'b0}};
            opb_q <= {WIDTH{1'b0}};
            div_q <= 1'b0;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
            if (load_i) begin
                opb_q <= mag_b_i;
                div_q <= mode_i;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle signed ALU with start/busy/done handshake: single-cycle
// arithmetic/logic ops plus iterative MUL/DIV with overflow and div-by-zero flags.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             imm_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             ov_excep,
    output logic             div0_excep
);

    localparam logic [WIDTH-1:0] MIN_NEG  = WIDTH'(min_neg(WIDTH));
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t             state_q, state_d;
    logic               busy_q, done_q, ov_q, dz_q;
    logic [WIDTH-1:0]   lo_q, hi_q;
    logic               div_q, neg_q, rem_neg_q;

    op_t                op_s;
    logic [WIDTH-1:0]   b_eff_s, sum_s, diff_s, mag_a_s, mag_b_s;
    logic               accept_s, div0_s, divov_s, iterative_s;
    logic [WIDTH-1:0]   sc_lo_s, sc_hi_s;
    logic               sc_ov_s, sc_dz_s;
    logic               last_iter_s;
    logic [WIDTH-1:0]   it_hi_s, it_lo_s, fix_lo_s, fix_hi_s;
    logic [2*WIDTH-1:0] prod_s;

    assign op_s        = op_t'(op);
    assign b_eff_s     = imm_sel ? imm : b;
    assign accept_s    = start && !busy_q;
    assign sum_s       = a + b_eff_s;
    assign diff_s      = a - b_eff_s;
    assign mag_a_s     = a[WIDTH-1] ? -a : a;
    assign mag_b_s     = b_eff_s[WIDTH-1] ? -b_eff_s : b_eff_s;
    assign div0_s      = (b_eff_s == ZERO);
    assign divov_s     = (a == MIN_NEG) && (b_eff_s == ALL_ONES);
    assign iterative_s = (op_s == OP_MUL) || ((op_s == OP_DIV) && !div0_s && !divov_s);

    seq_alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept_s && iterative_s),
        .step_i      (state_q == ITER),
        .mode_i      (op_s == OP_DIV),
        .mag_a_i     (mag_a_s),
        .mag_b_i     (mag_b_s),
        .last_iter_o (last_iter_s),
        .hi_o        (it_hi_s),
        .lo_o        (it_lo_s)
    );

    // Results of ops that complete in one cycle, including the DIV special cases.
    always_comb begin
        sc_lo_s = ZERO;
        sc_hi_s = ZERO;
        sc_ov_s = 1'b0;
        sc_dz_s = 1'b0;
        case (op_s)
            OP_ADD: begin
                sc_lo_s = sum_s;
                sc_ov_s = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo_s = diff_s;
                sc_ov_s = (a[WIDTH-1] != b_eff_s[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_lo_s = a & b_eff_s;
            OP_OR:   sc_lo_s = a | b_eff_s;
            OP_ADDR: sc_lo_s = sum_s;
            OP_DIV: begin
                if (div0_s) begin
                    sc_dz_s = 1'b1;
                    sc_hi_s = a;
                end else if (divov_s) begin
                    sc_ov_s = 1'b1;
                    sc_lo_s = a;
                end else begin
                    sc_lo_s = ZERO;
                end
            end
            default: sc_lo_s = ZERO;
        endcase
    end

    assign prod_s = neg_q ? -{it_hi_s, it_lo_s} : {it_hi_s, it_lo_s};

    // Sign correction applied to the unsigned engine output in FIX.
    always_comb begin
        if (div_q) begin
            fix_lo_s = neg_q ? -it_lo_s : it_lo_s;
            fix_hi_s = rem_neg_q ? -it_hi_s : it_hi_s;
        end else begin
            fix_lo_s = prod_s[WIDTH-1:0];
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state logic; DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_d = iterative_s ? ITER : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                if (last_iter_s) begin
                    state_d = FIX;
                end else begin
                    state_d = ITER;
                end
            end
            FIX:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ITER) || (state_d == FIX);
            done_q  <= (state_d == DONE);
        end
    end

    // Result, flag and sign capture; everything else holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q      <= ZERO;
            hi_q      <= ZERO;
            ov_q      <= 1'b0;
            dz_q      <= 1'b0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (accept_s) begin
            div_q     <= (op_s == OP_DIV);
            neg_q     <= a[WIDTH-1] ^ b_eff_s[WIDTH-1];
            rem_neg_q <= a[WIDTH-1];
            if (iterative_s) begin
                ov_q <= 1'b0;
                dz_q <= 1'b0;
            end else begin
                lo_q <= sc_lo_s;
                hi_q <= sc_hi_s;
                ov_q <= sc_ov_s;
                dz_q <= sc_dz_s;
            end
        end else if (state_q == FIX) begin
            lo_q <= fix_lo_s;
            hi_q <= fix_hi_s;
        end else begin
            lo_q <= lo_q;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result_lo  = lo_q;
    assign result_hi  = hi_q;
    assign ov_excep   = ov_q;
    assign div0_excep = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): directed cases plus random ops
// compared against a signed-integer reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n, start, imm_sel;
    logic [2:0]  op;
    logic [15:0] a, b, imm;
    logic        busy, done, ov_excep, div0_excep;
    logic [15:0] result_lo, result_hi;

    int checks = 0;
    int errors = 0;
    logic [15:0] prev_lo = 16'h0000;
    logic [15:0] prev_hi = 16'h0000;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        ov;
        logic        dz;
        int          lat;
    } exp_t;

    seq_alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .imm_sel    (imm_sel),
        .a          (a),
        .b          (b),
        .imm        (imm),
        .busy       (busy),
        .done       (done),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .ov_excep   (ov_excep),
        .div0_excep (div0_excep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer arithmetic on the operands.
    function automatic exp_t model(input int o, input logic [15:0] x, input logic [15:0] y);
        exp_t   e;
        longint sx, sy, r;
        sx = $signed(x);
        sy = $signed(y);
        e.lo = 16'h0000; e.hi = 16'h0000; e.ov = 1'b0; e.dz = 1'b0; e.lat = 1;
        case (o)
            0: begin r = sx + sy; e.lo = r[15:0]; e.ov = (r > 32767) || (r < -32768); end
            1: begin r = sx - sy; e.lo = r[15:0]; e.ov = (r > 32767) || (r < -32768); end
            2: e.lo = x & y;
            3: e.lo = x | y;
            4: begin r = sx * sy; e.lo = r[15:0]; e.hi = r[31:16]; e.lat = 18; end
            5: begin
                if (sy == 0) begin
                    e.dz = 1'b1; e.hi = x;
                end else if (sx == -32768 && sy == -1) begin
                    e.ov = 1'b1; e.lo = x;
                end else begin
                    r = sx / sy; e.lo = r[15:0];
                    r = sx % sy; e.hi = r[15:0];
                    e.lat = 18;
                end
            end
            6: begin r = sx + sy; e.lo = r[15:0]; end
            default: e.lo = 16'h0000;
        endcase
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] aa,
                          input logic [15:0] bb, input logic [15:0] ii, input logic s);
        exp_t e;
        int   lat;
        e = model(int'(o), aa, s ? ii : bb);
        @(negedge clk);
        op = o; a = aa; b = bb; imm = ii; imm_sel = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); imm = 16'($urandom); op = 3'($urandom);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            check({tag, "_busy"}, busy, lat < e.lat);
            if (lat < e.lat) begin
                check({tag, "_hold_lo"}, result_lo, prev_lo);
                if (lat == 1) begin
                    check({tag, "_flagclr"}, {ov_excep, div0_excep}, 2'b00);
                end
            end
            if (done) break;
            if (lat >= 40) begin
                check({tag, "_timeout"}, 1'b1, 1'b0);
                break;
            end
        end
        check({tag, "_lat"}, lat, e.lat);
        check({tag, "_lo"}, result_lo, e.lo);
        check({tag, "_hi"}, result_hi, e.hi);
        check({tag, "_ov"}, ov_excep, e.ov);
        check({tag, "_dz"}, div0_excep, e.dz);
        prev_lo = e.lo;
        prev_hi = e.hi;
        @(negedge clk);
        check({tag, "_onedone"}, done, 1'b0);
    endtask

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 6))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        exp_t e1, e2;
        int   lat, dones;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; imm_sel = 1'b0;
        a = 16'h0000; b = 16'h0000; imm = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_state", {busy, done, result_lo, result_hi, ov_excep, div0_excep}, 36'h0);
        rst_n = 1'b1;

        run_op("add_ov",   3'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0);
        run_op("add_imm",  3'd0, 16'h0005, 16'h1234, 16'hFFFF, 1'b1);
        run_op("sub_ov",   3'd1, 16'h8000, 16'h0001, 16'h0000, 1'b0);
        run_op("mul_neg",  3'd4, 16'hFFFD, 16'h0007, 16'h0000, 1'b0);
        run_op("div_neg",  3'd5, 16'hFFF9, 16'h0002, 16'h0000, 1'b0);
        run_op("div_zero", 3'd5, 16'h1234, 16'h0000, 16'h0000, 1'b0);
        run_op("div_ovf",  3'd5, 16'h8000, 16'hFFFF, 16'h0000, 1'b0);
        run_op("mul_min",  3'd4, 16'h8000, 16'h8000, 16'h0000, 1'b0);
        run_op("rsvd",     3'd7, 16'h1111, 16'h2222, 16'h0000, 1'b0);
        run_op("addr",     3'd6, 16'h7FFF, 16'h0001, 16'h0000, 1'b0);

        // start held high through a MUL; the AND behind it is taken in the DONE cycle
        e1 = model(4, 16'h0123, 16'hFFF0);
        e2 = model(2, 16'h0F0F, 16'h00FF);
        @(negedge clk);
        op = 3'd4; a = 16'h0123; b = 16'hFFF0; imm_sel = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        op = 3'd2; a = 16'h0F0F; b = 16'h00FF;
        dones = 0; lat = 0;
        while (lat < 18) begin
            @(negedge clk);
            lat++;
            if (done) dones++;
            if (lat < 18) check("hs_busy", busy, 1'b1);
        end
        check("hs_dones", dones, 1);
        check("hs_busy_done", busy, 1'b0);
        check("hs_mul", {result_hi, result_lo}, {e1.hi, e1.lo});
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("hs_and_done", done, 1'b1);
        check("hs_and", {result_hi, result_lo}, {e2.hi, e2.lo});
        @(negedge clk);
        check("hs_single", done, 1'b0);
        prev_lo = e2.lo; prev_hi = e2.hi;

        // reset in the middle of a DIV
        @(negedge clk);
        op = 3'd5; a = 16'h1234; b = 16'h0005; imm_sel = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("rmid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rmid_zero", {busy, done, result_lo, result_hi, ov_excep, div0_excep}, 36'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rmid_nodone", done, 1'b0);
        end
        rst_n = 1'b1;
        prev_lo = 16'h0000; prev_hi = 16'h0000;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            check("rmid_quiet", done, 1'b0);
        end
        run_op("post_rst", 3'd0, 16'h0100, 16'h0023, 16'h0000, 1'b0);

        for (int i = 0; i < 250; i++) begin
            run_op("rnd", 3'($urandom_range(0, 7)), rand_val(), rand_val(), rand_val(),
                   1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
